spi_leader_transceiver: RTL and testbench
=========================================

Name: spi_leader_transceiver

Overview:
Parametrised, full-duplex SPI leader. It is the next generation of the team's fixed 8-bit, transmit-only SPI leader, adding:
- configurable frame width and sck divider
- all four CPOL/CPHA modes
- MISO capture
- multiple active-low slave selects
- LSB/MSB-first ordering
- done/busy handshake

It sits between user logic on the system clock and external SPI followers, including the team's follower receiver.

Parameters:
DATA_W, 8, frame width in bits (>=2).
CLK_DIV, 4, sck half-period in clk cycles (>=2).
NUM_SS, 1, number of slave-select outputs (>=1).
SS_SEL_W, 1, width of ss_sel; the integrator sets it >= clog2(NUM_SS), minimum 1.
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
datain  input  DATA_W  transmit word; latched when send is accepted.
send  input  1  transfer request; level-sensitive, accepted only in IDLE.
cpol  input  1  clock polarity; latched on accept.
cpha  input  1  clock phase; latched on accept.
ss_sel  input  SS_SEL_W  follower index; latched on accept.
miso  input  1  serial data from follower.
sck  output  1  SPI clock.
ss  output  NUM_SS  active-low selects.
mosi  output  1  serial data to follower.
busy  output  1  high from the cycle after accept until return to IDLE.
done  output  1  one-cycle pulse when dataout is valid.
dataout  output  DATA_W  received word.

Behaviour:
Reset (synchronous, wins over everything, including mid-transfer):
- state=IDLE; sck=0, ss=all 1, mosi=0, busy=0, done=0, dataout=0.
- A transfer interrupted by reset is abandoned: no done pulse; ss is all 1 on the next edge.

States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE. A half-period counter counts 0..CLK_DIV-1 and gates all transitions.

IDLE:
- sck = registered cpol input; ss all 1; busy=0.
- send=1 at edge T0: latch datain, cpol, cpha, ss_sel; go to SETUP.
- At T0+1: busy=1; ss[ss_sel]=0 if ss_sel<NUM_SS, otherwise no select asserts but the frame still runs.

SETUP (CLK_DIV cycles):
- sck = latched cpol.
- cpha=0: mosi = first bit.
- cpha=1: mosi holds 0.

XFER (2*DATA_W*CLK_DIV cycles):
- sck toggles at each half-period boundary: DATA_W leading edges and DATA_W trailing edges.
- cpha=0: sample miso on each leading edge; drive the next mosi bit on each trailing edge, except the last.
- cpha=1: drive mosi on each leading edge; sample miso on each trailing edge.
- Bit order follows MSB_FIRST for both shift-out and shift-in.

HOLD (CLK_DIV cycles):
- sck = cpol; ss held; mosi holds its last bit.

GAP (CLK_DIV cycles):
- On the entry edge: ss all 1; dataout updated; done=1 for exactly that cycle.
- busy stays 1 until GAP ends, giving guaranteed ss-high time of CLK_DIV cycles.

Timing and handshake:
- Total busy time = CLK_DIV*(2*DATA_W+3) cycles.
- send while busy is ignored; datain/cpol/cpha/ss_sel changes mid-frame have no effect.
- send held high gives back-to-back frames, with ss high for exactly CLK_DIV cycles between frames.
- dataout holds its value until the next done.

Test Plan:
1. DATA_W=8, CLK_DIV=4, mode 0, miso looped from mosi, datain=0x95 -> mosi bits 1,0,0,1,0,1,0,1 at the 8 rising sck edges; dataout=0x95; done 1 cycle; busy high 76 cycles.
2. cpol=1, cpha=1, datain=0x54, a follower model returns 0xA3 -> sck idles high; 8 falling-edge launches; dataout=0xA3; mosi frame decodes 0x54.
3. send held at 1; datain changes 0x95->0x54 at cycle 20 of frame 1 -> frame 1 sends 0x95, frame 2 sends 0x54; ss high exactly 4 cycles between frames; two done pulses.
4. NUM_SS=4, SS_SEL_W=2, ss_sel=2 -> only ss[2] low during the frame. NUM_SS=4, SS_SEL_W=3, ss_sel=5 -> ss stays 4'hF; done still pulses.
5. reset at cycle 30 of a frame -> next cycle ss all 1, sck=0, busy=0, dataout=0, no done; a fresh send then completes normally.
6. MSB_FIRST=0, datain=0x01, mode 0 -> first mosi bit 1, then seven 0s; looped-back dataout=0x01.

Source files
------------

// File: rtl/spi_leader_transceiver.sv
// Full-duplex SPI leader with configurable frame width, sck divider, CPOL/CPHA,
// bit order and active-low slave selects, plus a busy/done handshake.
module spi_leader_transceiver #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int NUM_SS    = 1,
  parameter int SS_SEL_W  = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   datain,
  input  logic                send,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [SS_SEL_W-1:0] ss_sel,
  input  logic                miso,
  output logic                sck,
  output logic [NUM_SS-1:0]   ss,
  output logic                mosi,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   dataout
);

  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [NUM_SS-1:0] SS_IDLE   = {NUM_SS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [HALF_W-1:0]   half_r, half_s;
  logic                sck_r, sck_s;
  logic [NUM_SS-1:0]   ss_r, ss_s;
  logic                mosi_r, mosi_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [DATA_W-1:0]   dataout_r, dataout_s;
  logic [DATA_W-1:0]   tx_r, tx_s;
  logic [DATA_W-1:0]   rx_r, rx_s;
  logic                cpol_r, cpol_s;
  logic                cpha_r, cpha_s;
  logic                period_end_s;
  logic                tog_s;
  logic                lead_s;
  logic                final_s;
  logic                accept_s;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return w[DATA_W-1];
    end else begin
      return w[0];
    end
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      return {w[DATA_W-2:0], 1'b0};
    end else begin
      return {1'b0, w[DATA_W-1:1]};
    end
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    if (MSB_FIRST != 0) begin
      return {w[DATA_W-2:0], b};
    end else begin
      return {b, w[DATA_W-1:1]};
    end
  endfunction

  // An out-of-range index selects nobody; the frame still runs.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_SEL_W-1:0] sel);
    logic [NUM_SS-1:0] r;
    r = SS_IDLE;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) begin
        r[i] = 1'b0;
      end else begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Next-state and next-output logic for every register.
  always_comb begin
    state_s      = state_r;
    half_s       = half_r;
    sck_s        = sck_r;
    ss_s         = ss_r;
    mosi_s       = mosi_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    dataout_s    = dataout_r;
    tx_s         = tx_r;
    rx_s         = rx_r;
    cpol_s       = cpol_r;
    cpha_s       = cpha_r;
    tog_s        = 1'b0;
    lead_s       = 1'b0;
    final_s      = 1'b0;
    accept_s     = 1'b0;
    period_end_s = (cnt_r == CNT_LAST);
    if (period_end_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1'b1);
    end

    case (state_r)
      S_IDLE: begin
        cnt_s    = {CNT_W{1'b0}};
        sck_s    = cpol;
        ss_s     = SS_IDLE;
        busy_s   = 1'b0;
        accept_s = send;
      end
      S_SETUP: begin
        if (period_end_s) begin
          state_s = S_XFER;
          half_s  = {HALF_W{1'b0}};
          tog_s   = 1'b1;
          lead_s  = 1'b1;
        end else begin
          sck_s = cpol_r;
        end
      end
      S_XFER: begin
        if (period_end_s && (half_r == HALF_LAST)) begin
          state_s = S_HOLD;
          sck_s   = cpol_r;
        end else if (period_end_s) begin
          // Toggle index is half_r+1: even indices are leading edges.
          half_s  = half_r + HALF_W'(1'b1);
          tog_s   = 1'b1;
          lead_s  = half_r[0];
          final_s = (half_r == (HALF_LAST - HALF_W'(1'b1)));
        end else begin
          half_s = half_r;
        end
      end
      S_HOLD: begin
        if (period_end_s) begin
          state_s   = S_GAP;
          ss_s      = SS_IDLE;
          dataout_s = rx_r;
          done_s    = 1'b1;
        end else begin
          sck_s = cpol_r;
        end
      end
      S_GAP: begin
        // A held send restarts straight from the end of GAP so ss stays high
        // for exactly CLK_DIV cycles between back-to-back frames.
        if (period_end_s && send) begin
          accept_s = 1'b1;
        end else if (period_end_s) begin
          state_s = S_IDLE;
          busy_s  = 1'b0;
          sck_s   = cpol;
        end else begin
          ss_s = SS_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
        ss_s    = SS_IDLE;
      end
    endcase

    if (tog_s) begin
      sck_s = ~sck_r;
      if (lead_s ^ cpha_r) begin
        rx_s = shift_in(rx_r, miso);
      end else if (cpha_r) begin
        mosi_s = first_bit(tx_r);
        tx_s   = shift_out(tx_r);
      end else if (!final_s) begin
        mosi_s = first_bit(shift_out(tx_r));
        tx_s   = shift_out(tx_r);
      end else begin
        mosi_s = mosi_r;
      end
    end else begin
      rx_s = rx_r;
    end

    if (accept_s) begin
      state_s = S_SETUP;
      cnt_s   = {CNT_W{1'b0}};
      half_s  = {HALF_W{1'b0}};
      cpol_s  = cpol;
      cpha_s  = cpha;
      tx_s    = datain;
      rx_s    = {DATA_W{1'b0}};
      sck_s   = cpol;
      ss_s    = ss_decode(ss_sel);
      busy_s  = 1'b1;
      mosi_s  = cpha ? 1'b0 : first_bit(datain);
    end else begin
      cpol_s = cpol_r;
      cpha_s = cpha_r;
    end
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      half_r    <= {HALF_W{1'b0}};
      sck_r     <= 1'b0;
      ss_r      <= SS_IDLE;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dataout_r <= {DATA_W{1'b0}};
      tx_r      <= {DATA_W{1'b0}};
      rx_r      <= {DATA_W{1'b0}};
      cpol_r    <= 1'b0;
      cpha_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      half_r    <= half_s;
      sck_r     <= sck_s;
      ss_r      <= ss_s;
      mosi_r    <= mosi_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      dataout_r <= dataout_s;
      tx_r      <= tx_s;
      rx_r      <= rx_s;
      cpol_r    <= cpol_s;
      cpha_r    <= cpha_s;
    end
  end

  assign sck     = sck_r;
  assign ss      = ss_r;
  assign mosi    = mosi_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign dataout = dataout_r;

endmodule

// File: tb/tb_spi_leader_transceiver.sv
// Two leaders (MSB-first and LSB-first) run in lockstep against an SPI-level
// follower/monitor that decodes mosi and drives miso from the sck edges it sees.
module tb_spi_leader_transceiver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic       send;
  logic       cpol;
  logic       cpha;
  logic [2:0] ss_sel;

  logic [1:0] sck_w, mosi_w, busy_w, done_w, miso_w;
  logic [3:0] ss_w [2];
  logic [7:0] dataout_w [2];

  bit         loopback;
  logic [7:0] resp_word;
  bit         f_cpol, f_cpha;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit MSBF = (g == 0);
    logic       fmiso = 1'b0;
    int         fidx = 0, busy_cyc = 0, done_cnt = 0, toggles = 0, nbits = 0;
    logic [7:0] mword = 8'h00;
    logic       first_mosi = 1'b0;
    logic [3:0] ss_and = 4'hF, ss_or = 4'h0;
    logic       prev_sck = 1'b0, prev_busy = 1'b0, prev_done = 1'b0, seen_done = 1'b0;
    logic       lead;

    function automatic logic resp_bit(input int i);
      if (i > 7) return 1'b0;
      return MSBF ? resp_word[7-i] : resp_word[i];
    endfunction

    assign miso_w[g] = loopback ? mosi_w[g] : fmiso;

    spi_leader_transceiver #(
      .DATA_W(8), .CLK_DIV(4), .NUM_SS(4), .SS_SEL_W(3), .MSB_FIRST(MSBF ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset), .datain(datain), .send(send), .cpol(cpol),
      .cpha(cpha), .ss_sel(ss_sel), .miso(miso_w[g]), .sck(sck_w[g]),
      .ss(ss_w[g]), .mosi(mosi_w[g]), .busy(busy_w[g]), .done(done_w[g]),
      .dataout(dataout_w[g])
    );

    // SPI-level follower and bus monitor, evaluated away from the active edge.
    always @(negedge clk) begin
      if (busy_w[g] && !prev_busy) begin
        busy_cyc = 0; done_cnt = 0; toggles = 0; seen_done = 1'b0;
        ss_and = 4'hF; ss_or = 4'h0;
      end
      if ((busy_w[g] && !prev_busy) || prev_done) begin
        nbits = 0; fidx = 0; mword = 8'h00;
        fmiso = resp_bit(0);
      end
      if (busy_w[g]) busy_cyc++;
      if (done_w[g]) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      if (busy_w[g] && !done_w[g] && !seen_done) begin
        ss_and = ss_and & ss_w[g];
        ss_or  = ss_or | ss_w[g];
      end
      if (busy_w[g] && prev_busy && (sck_w[g] != prev_sck)) begin
        toggles++;
        lead = (sck_w[g] != f_cpol);
        if (lead ^ f_cpha) begin
          if (nbits == 0) first_mosi = mosi_w[g];
          mword = MSBF ? {mword[6:0], mosi_w[g]} : {mosi_w[g], mword[7:1]};
          nbits++;
        end else if (f_cpha) begin
          fmiso = resp_bit(fidx);
          fidx++;
        end else begin
          fidx++;
          fmiso = resp_bit(fidx);
        end
      end
      prev_sck  = sck_w[g];
      prev_busy = busy_w[g];
      prev_done = done_w[g];
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_ss(input logic [2:0] sel);
    logic [3:0] r;
    r = 4'hF;
    if (sel < 3'd4) r[sel[1:0]] = 1'b0;
    return r;
  endfunction

  task automatic wait_done(input string tag, input bit pulse_send);
    int n;
    n = 0;
    while (!done_w[0] && n < 300) begin
      if (pulse_send) send = (n >= 30 && n < 34);
      tick;
      n++;
    end
    check({tag, "_done0"}, {31'd0, done_w[0]}, 32'd1);
    check({tag, "_done1"}, {31'd0, done_w[1]}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_w[0] && n < 300) begin
      tick;
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy_w[0]}, 32'd0);
  endtask

  task automatic start_frame(input logic [7:0] d, input bit c_pol, input bit c_pha,
                             input logic [2:0] sel, input bit lb, input logic [7:0] resp);
    loopback = lb; resp_word = resp; f_cpol = c_pol; f_cpha = c_pha;
    datain = d; cpol = c_pol; cpha = c_pha; ss_sel = sel;
    tick;
    tick;
    check("idle_sck", {31'd0, sck_w[0]}, {31'd0, c_pol});
    check("idle_ss", {28'd0, ss_w[0]}, 32'hF);
    send = 1'b1;
    tick;
    send = 1'b0;
    check("busy_after_accept", {31'd0, busy_w[0]}, 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit c_pol,
                           input bit c_pha, input logic [2:0] sel, input bit lb,
                           input logic [7:0] resp, input bit scramble);
    logic [7:0] exp_out;
    exp_out = lb ? d : resp;
    start_frame(d, c_pol, c_pha, sel, lb, resp);
    if (scramble) begin
      datain = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
      ss_sel = 3'($urandom);
    end
    wait_done(tag, scramble);
    check({tag, "_dout_msb"}, {24'd0, dataout_w[0]}, {24'd0, exp_out});
    check({tag, "_dout_lsb"}, {24'd0, dataout_w[1]}, {24'd0, exp_out});
    check({tag, "_mosi_msb"}, {24'd0, g_dut[0].mword}, {24'd0, d});
    check({tag, "_mosi_lsb"}, {24'd0, g_dut[1].mword}, {24'd0, d});
    check({tag, "_nbits"}, 32'(g_dut[0].nbits), 32'd8);
    check({tag, "_first_msb"}, {31'd0, g_dut[0].first_mosi}, {31'd0, d[7]});
    check({tag, "_first_lsb"}, {31'd0, g_dut[1].first_mosi}, {31'd0, d[0]});
    check({tag, "_ss_and"}, {28'd0, g_dut[0].ss_and}, {28'd0, exp_ss(sel)});
    check({tag, "_ss_or"}, {28'd0, g_dut[0].ss_or}, {28'd0, exp_ss(sel)});
    check({tag, "_ss_gap"}, {28'd0, ss_w[0]}, 32'hF);
    wait_idle(tag);
    check({tag, "_busy_cycles"}, 32'(g_dut[0].busy_cyc), 32'd76);
    check({tag, "_done_pulses"}, 32'(g_dut[0].done_cnt), 32'd1);
    check({tag, "_sck_edges"}, 32'(g_dut[0].toggles), 32'd16);
    tick;
    check({tag, "_dout_hold"}, {24'd0, dataout_w[0]}, {24'd0, exp_out});
  endtask

  initial begin
    int run;
    bit dropped;
    reset = 1'b1; send = 1'b0; datain = 8'h00; cpol = 1'b0; cpha = 1'b0;
    ss_sel = 3'd0; loopback = 1'b1; resp_word = 8'h00; f_cpol = 1'b0; f_cpha = 1'b0;
    tick;
    tick;
    for (int g = 0; g < 2; g++) begin
      check("rst_sck", {31'd0, sck_w[g]}, 32'd0);
      check("rst_ss", {28'd0, ss_w[g]}, 32'hF);
      check("rst_mosi", {31'd0, mosi_w[g]}, 32'd0);
      check("rst_busy", {31'd0, busy_w[g]}, 32'd0);
      check("rst_done", {31'd0, done_w[g]}, 32'd0);
      check("rst_dout", {24'd0, dataout_w[g]}, 32'd0);
    end
    reset = 1'b0;
    tick;

    run_frame("mode0_loop", 8'h95, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    run_frame("mode3_follower", 8'h54, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA3, 1'b0);
    run_frame("sel2", 8'h3C, 1'b0, 1'b1, 3'd2, 1'b0, 8'h5A, 1'b0);
    run_frame("sel5", 8'hC6, 1'b1, 1'b0, 3'd5, 1'b1, 8'h00, 1'b0);
    run_frame("lsb_one", 8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 8'h00, 1'b0);

    // Back-to-back frames with datain changing mid-frame.
    start_frame(8'h95, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00);
    send = 1'b1;
    repeat (19) tick;
    datain = 8'h54;
    wait_done("b2b_f1", 1'b0);
    check("b2b_f1_mosi", {24'd0, g_dut[0].mword}, 32'h95);
    check("b2b_f1_dout", {24'd0, dataout_w[1]}, 32'h95);
    run = 0;
    dropped = 1'b0;
    while (ss_w[0] == 4'hF && run < 20) begin
      if (!busy_w[0]) dropped = 1'b1;
      run++;
      tick;
    end
    send = 1'b0;
    check("b2b_ss_high_cycles", 32'(run), 32'd4);
    check("b2b_busy_held", {31'd0, dropped}, 32'd0);
    wait_done("b2b_f2", 1'b0);
    check("b2b_f2_mosi", {24'd0, g_dut[0].mword}, 32'h54);
    check("b2b_f2_dout", {24'd0, dataout_w[0]}, 32'h54);
    wait_idle("b2b");
    check("b2b_done_pulses", 32'(g_dut[0].done_cnt), 32'd2);

    // Reset 30 cycles into a frame abandons it.
    start_frame(8'hE7, 1'b1, 1'b1, 3'd3, 1'b0, 8'h81);
    repeat (29) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrst_ss", {28'd0, ss_w[0]}, 32'hF);
    check("midrst_sck", {31'd0, sck_w[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
    check("midrst_dout", {24'd0, dataout_w[0]}, 32'd0);
    check("midrst_done", {31'd0, done_w[0]}, 32'd0);
    repeat (80) tick;
    check("midrst_no_done", 32'(g_dut[0].done_cnt), 32'd0);
    run_frame("after_rst", 8'h6B, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0);

    // Randomised frames with inputs scrambled and send pulsed mid-frame.
    for (int i = 0; i < 12; i++) begin
      run_frame("rand", 8'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom_range(0, 5)), 1'($urandom), 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
